paddle_controller: RTL



---
 rtl/paddle_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/paddle_controller.sv
// Pong player input sequencer: edge-detects two encoder front-ends, runs the READY/RUN/PAUSED
// game FSM, keeps clamped paddle positions and streams position changes over valid/ready.
module paddle_controller #(
  parameter int POS_W    = 10,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 400,
  parameter int POS_INIT = 200,
  parameter int STEP     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_up,
  input  logic             p0_down,
  input  logic             p0_button,
  input  logic             p1_up,
  input  logic             p1_down,
  input  logic             p1_button,
  output logic [POS_W-1:0] p0_pos,
  output logic [POS_W-1:0] p1_pos,
  output logic             run,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic             upd_player,
  output logic [POS_W-1:0] upd_pos
);
  localparam int EXT_W = POS_W + 1;
  localparam logic [EXT_W-1:0] MIN_X      = EXT_W'(POS_MIN);
  localparam logic [EXT_W-1:0] MAX_X      = EXT_W'(POS_MAX);
  localparam logic [EXT_W-1:0] STEP_X     = EXT_W'(STEP);
  localparam logic [EXT_W-1:0] MIN_STEP_X = EXT_W'(POS_MIN + STEP);

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [1:0] up_in, down_in, btn_in;
  logic [1:0] up_hist_reg, down_hist_reg, btn_hist_reg;
  logic [1:0] up_ev, down_ev, btn_ev;
  logic [1:0] ready_reg, ready_next;
  logic [1:0] pending_reg, pending_next;
  logic [1:0] changed;
  logic [1:0][POS_W-1:0] pos_cur;
  logic last_grant_reg, last_grant_next;
  logic upd_valid_reg, upd_valid_next;
  logic upd_player_reg, upd_player_next;
  logic [POS_W-1:0] upd_pos_reg, upd_pos_next;
  logic grant;
  logic moving;

  assign up_in   = {p1_up, p0_up};
  assign down_in = {p1_down, p0_down};
  assign btn_in  = {p1_button, p0_button};
  assign up_ev   = up_in & ~up_hist_reg;
  assign down_ev = down_in & ~down_hist_reg;
  assign btn_ev  = btn_in & ~btn_hist_reg;
  assign moving  = (state_reg == ST_RUN);

  // Per-player position datapath; arithmetic is one bit wider so the up-sum cannot wrap.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      logic [POS_W-1:0] pos_reg, pos_next;
      logic [EXT_W-1:0] pos_x, up_sum, up_val, dn_val;
      logic move_up, move_dn;

      assign pos_x   = {1'b0, pos_reg};
      assign up_sum  = pos_x + STEP_X;
      assign up_val  = (up_sum > MAX_X) ? MAX_X : up_sum;
      assign dn_val  = (pos_x < MIN_STEP_X) ? MIN_X : (pos_x - STEP_X);
      assign move_up = moving & up_ev[gi] & ~down_ev[gi];
      assign move_dn = moving & down_ev[gi] & ~up_ev[gi];
      assign pos_next = move_up ? up_val[POS_W-1:0] :
                        (move_dn ? dn_val[POS_W-1:0] : pos_reg);
      assign changed[gi] = (pos_next != pos_reg);
      assign pos_cur[gi] = pos_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) pos_reg <= POS_W'(POS_INIT);
        else        pos_reg <= pos_next;
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ready_next = ready_reg;
    case (state_reg)
      ST_READY: begin
        ready_next = ready_reg | btn_ev;
        if (&ready_next) begin
          state_next = ST_RUN;
          ready_next = 2'b00;
        end
      end
      ST_RUN:    if (|btn_ev) state_next = ST_PAUSED;
      ST_PAUSED: if (|btn_ev) state_next = ST_RUN;
      default:   state_next = ST_READY;
    endcase
  end

  // Output stage samples the pre-edge position; a change in the same cycle re-arms pending.
  always_comb begin
    pending_next    = pending_reg;
    last_grant_next = last_grant_reg;
    upd_valid_next  = upd_valid_reg;
    upd_player_next = upd_player_reg;
    upd_pos_next    = upd_pos_reg;
    grant           = 1'b0;
    if (!upd_valid_reg || upd_ready) begin
      if (pending_reg == 2'b11) begin
        grant           = ~last_grant_reg;
        last_grant_next = grant;
      end else begin
        grant = pending_reg[1];
      end
      if (|pending_reg) begin
        upd_valid_next      = 1'b1;
        upd_player_next     = grant;
        upd_pos_next        = pos_cur[grant];
        pending_next[grant] = 1'b0;
      end else begin
        upd_valid_next = 1'b0;
      end
    end
    pending_next = pending_next | changed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_READY;
      ready_reg      <= 2'b00;
      pending_reg    <= 2'b00;
      last_grant_reg <= 1'b1;
      upd_valid_reg  <= 1'b0;
      upd_player_reg <= 1'b0;
      upd_pos_reg    <= '0;
      up_hist_reg    <= 2'b00;
      down_hist_reg  <= 2'b00;
      btn_hist_reg   <= 2'b00;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= ready_next;
      pending_reg    <= pending_next;
      last_grant_reg <= last_grant_next;
      upd_valid_reg  <= upd_valid_next;
      upd_player_reg <= upd_player_next;
      upd_pos_reg    <= upd_pos_next;
      up_hist_reg    <= up_in;
      down_hist_reg  <= down_in;
      btn_hist_reg   <= btn_in;
    end
  end

  assign p0_pos     = pos_cur[0];
  assign p1_pos     = pos_cur[1];
  assign run        = moving;
  assign upd_valid  = upd_valid_reg;
  assign upd_player = upd_player_reg;
  assign upd_pos    = upd_pos_reg;
endmodule
